keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad and debounces the result.
- Produces the `keypad_pressed` level and 5-bit `key` code consumed directly by the game state machine. That FSM uses codes 10 = PWRB, 13 = STB, 14 = NO, 15 = YES.
- Sits between the board keypad pins and the game FSM; runs on the 27 MHz system clock.

---
 rtl/keypad_pkg.sv | 44 ++++
 rtl/keypad_sync.sv | 23 ++
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 tb/tb_keypad_scanner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the scan state enum, game key codes and the row/col code table.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  localparam logic [4:0] KEY_PWRB = 5'd10;
  localparam logic [4:0] KEY_STB  = 5'd13;
  localparam logic [4:0] KEY_NO   = 5'd14;
  localparam logic [4:0] KEY_YES  = 5'd15;
  localparam logic [4:0] KEY_NONE = 5'd31;

  // Indexed by {row, col}.
  localparam logic [4:0] CODE_TABLE [16] = '{
    5'd1,   5'd2, 5'd3,    KEY_PWRB,
    5'd4,   5'd5, 5'd6,    5'd11,
    5'd7,   5'd8, 5'd9,    5'd12,
    KEY_NO, 5'd0, KEY_YES, KEY_STB
  };

  // Lowest low column wins when several are pressed.
  function automatic logic [1:0] first_low(
    input logic [3:0] c
  );
    logic [1:0] idx;
    idx = 2'd3;
    if (!c[0])      idx = 2'd0;
    else if (!c[1]) idx = 2'd1;
    else if (!c[2]) idx = 2'd2;
    return idx;
  endfunction

  function automatic logic [4:0] key_code(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return CODE_TABLE[{r, c}];
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// 4-bit two-flop synchronizer for the raw keypad columns.
// Ports: clk, rst (sync, active-high), d (async in), q (synced out).
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Columns idle high (pulled up), so reset to all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Ports: clk, rst (sync, active-high), col_in[3:0] (active-low, async),
//        row_n[3:0] (active-low one-hot), key[4:0], keypad_pressed,
//        key_valid (one-cycle pulse per accepted press).
// Optional: define KEYPAD_REPEAT_EN for auto-repeat key_valid pulses.
module keypad_scanner #(
  parameter int SCAN_DIV     = 27000,
  parameter int DEBOUNCE_CNT = 10,
  parameter int REPEAT_CNT   = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_n,
  output logic [4:0] key,
  output logic       keypad_pressed,
  output logic       key_valid
);

  import keypad_pkg::*;

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DB_DONE  = SW'(DEBOUNCE_CNT);

  logic [3:0]    col_s;
  logic [DW-1:0] dwell;
  logic [SW-1:0] stable;
  logic [1:0]    row;
  logic [1:0]    cand_row;
  logic [1:0]    cand_col;
  state_t        state;
  logic          sample;
  logic          cand_high;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CNT - 1);
  logic [RW-1:0] rpt;
`endif

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_in),
    .q   (col_s)
  );

  assign sample    = (dwell == DIV_LAST);
  assign cand_high = col_s[cand_col];

  always_ff @(posedge clk) begin
    if (rst || sample) dwell <= '0;
    else               dwell <= dwell + DW'(1);
  end

  // Acceptance/release fire on the edge after stable reaches its
  // terminal value; SCAN_DIV >= 4 keeps that edge off a sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SCAN;
      row            <= 2'd0;
      row_n          <= 4'b1110;
      cand_row       <= 2'd0;
      cand_col       <= 2'd0;
      stable         <= '0;
      key            <= KEY_NONE;
      keypad_pressed <= 1'b0;
      key_valid      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt            <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (sample) begin
            if (&col_s) begin
              row   <= row + 2'd1;
              row_n <= {row_n[2:0], row_n[3]};
            end else begin
              cand_row <= row;
              cand_col <= first_low(col_s);
              stable   <= SW'(1);
              state    <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (stable == DB_DONE) begin
            key            <= key_code(cand_row, cand_col);
            keypad_pressed <= 1'b1;
            key_valid      <= 1'b1;
            stable         <= '0;
            state          <= HELD;
`ifdef KEYPAD_REPEAT_EN
            rpt            <= '0;
`endif
          end else if (sample) begin
            if (!cand_high) begin
              stable <= stable + SW'(1);
            end else begin
              stable <= '0;
              state  <= SCAN;
              row    <= row + 2'd1;
              row_n  <= {row_n[2:0], row_n[3]};
            end
          end
        end
        HELD: begin
          if (stable == DB_DONE) begin
            key            <= KEY_NONE;
            keypad_pressed <= 1'b0;
            stable         <= '0;
            state          <= SCAN;
            row            <= row + 2'd1;
            row_n          <= {row_n[2:0], row_n[3]};
`ifdef KEYPAD_REPEAT_EN
            rpt            <= '0;
`endif
          end else if (sample) begin
            if (cand_high) stable <= stable + SW'(1);
            else           stable <= '0;
`ifdef KEYPAD_REPEAT_EN
            if (!cand_high) begin
              if (rpt == RP_LAST) begin
                key_valid <= 1'b1;
                rpt       <= '0;
              end else begin
                rpt <= rpt + RW'(1);
              end
            end
`endif
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed table-driven bench for keypad_scanner.
// Uses SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CNT=5 and a keypad matrix model.
module tb_keypad_scanner;

  localparam logic [3:0] R0 = 4'b1110;
  localparam logic [3:0] R1 = 4'b1101;
  localparam logic [3:0] R2 = 4'b1011;
  localparam logic [3:0] R3 = 4'b0111;
  localparam logic [4:0] NK = 5'd31;

`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_RPT = 4;
`else
  localparam int EXP_RPT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_n;
  logic [4:0]  key;
  logic        keypad_pressed;
  logic        key_valid;
  logic [15:0] keys = '0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  row_n;
    logic [4:0]  key;
    logic        pressed;
    int          pulses;
    bit          rst_first;
    bit          hold_after;
  } vec_t;

  vec_t tbl[$];

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3),
    .REPEAT_CNT   (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .col_in         (col_in),
    .row_n          (row_n),
    .key            (key),
    .keypad_pressed (keypad_pressed),
    .key_valid      (key_valid)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (row_n[r] == 1'b0)) col_in[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] k, input logic [3:0] rn,
                     input logic [4:0] kc, input logic p, input int pl,
                     input bit rs, input bit hd);
    vec_t v;
    v.keys = k; v.row_n = rn; v.key = kc; v.pressed = p;
    v.pulses = pl; v.rst_first = rs; v.hold_after = hd;
    tbl.push_back(v);
  endtask

  // Leaves the bench one negedge after the first post-reset edge.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_row_n", 32'(row_n), 32'(R0));
    chk("rst_key", 32'(key), 32'(NK));
    chk("rst_pressed", 32'(keypad_pressed), 0);
    chk("rst_valid", 32'(key_valid), 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_step(input int idx, input vec_t v);
    int n;
    keys = v.keys;
    n = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid) n++;
    end
    chk($sformatf("s%0d_row_n", idx), 32'(row_n), 32'(v.row_n));
    chk($sformatf("s%0d_key", idx), 32'(key), 32'(v.key));
    chk($sformatf("s%0d_pressed", idx), 32'(keypad_pressed),
        32'(v.pressed));
    chk($sformatf("s%0d_pulses", idx), 32'(n), 32'(v.pulses));
  endtask

  task automatic hold_run();
    int n;
    bit dropped;
    n = 0;
    dropped = 0;
    repeat (20 * 4) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid) n++;
      if (!keypad_pressed) dropped = 1;
    end
    chk("hold_pulses", 32'(n), 32'(EXP_RPT));
    chk("hold_dropped", 32'(dropped), 0);
    chk("hold_key", 32'(key), 32'(5'd15));
  endtask

  initial begin
    // Idle scan through all rows and wrap.
    add(16'h0, R1, NK, 0, 0, 0, 0);
    add(16'h0, R2, NK, 0, 0, 0, 0);
    add(16'h0, R3, NK, 0, 0, 0, 0);
    add(16'h0, R0, NK, 0, 0, 0, 0);
    add(16'h0, R1, NK, 0, 0, 0, 0);
    // Row 0 col 3 (PWRB), clean press and release.
    add(16'h0008, R2, NK, 0, 0, 0, 0);
    add(16'h0008, R3, NK, 0, 0, 0, 0);
    add(16'h0008, R0, NK, 0, 0, 0, 0);
    add(16'h0008, R0, NK, 0, 0, 0, 0);
    add(16'h0008, R0, NK, 0, 0, 0, 0);
    add(16'h0008, R0, 5'd10, 1, 1, 0, 0);
    add(16'h0000, R0, 5'd10, 1, 0, 0, 0);
    add(16'h0000, R0, 5'd10, 1, 0, 0, 0);
    add(16'h0000, R1, NK, 0, 0, 0, 0);
    // Row 3 col 1 bounces, then holds (code 0).
    add(16'h2000, R2, NK, 0, 0, 0, 0);
    add(16'h2000, R3, NK, 0, 0, 0, 0);
    add(16'h2000, R3, NK, 0, 0, 0, 0);
    add(16'h0000, R0, NK, 0, 0, 0, 0);
    add(16'h2000, R1, NK, 0, 0, 0, 0);
    add(16'h2000, R2, NK, 0, 0, 0, 0);
    add(16'h2000, R3, NK, 0, 0, 0, 0);
    add(16'h2000, R3, NK, 0, 0, 0, 0);
    add(16'h2000, R3, NK, 0, 0, 0, 0);
    add(16'h2000, R3, 5'd0, 1, 1, 0, 0);
    add(16'h0000, R3, 5'd0, 1, 0, 0, 0);
    add(16'h0000, R3, 5'd0, 1, 0, 0, 0);
    add(16'h0000, R0, NK, 0, 0, 0, 0);
    // Row 3 cols 0+2 together -> NO; row 1 col 1 ignored while held.
    add(16'h5000, R1, NK, 0, 0, 0, 0);
    add(16'h5000, R2, NK, 0, 0, 0, 0);
    add(16'h5000, R3, NK, 0, 0, 0, 0);
    add(16'h5000, R3, NK, 0, 0, 0, 0);
    add(16'h5000, R3, NK, 0, 0, 0, 0);
    add(16'h5000, R3, 5'd14, 1, 1, 0, 0);
    add(16'h5020, R3, 5'd14, 1, 0, 0, 0);
    add(16'h5020, R3, 5'd14, 1, 0, 0, 0);
    add(16'h0000, R3, 5'd14, 1, 0, 0, 0);
    add(16'h0000, R3, 5'd14, 1, 0, 0, 0);
    add(16'h0000, R0, NK, 0, 0, 0, 0);
    // Row 3 col 3 (STB), reset mid-hold, re-accepted afterwards.
    add(16'h8000, R1, NK, 0, 0, 0, 0);
    add(16'h8000, R2, NK, 0, 0, 0, 0);
    add(16'h8000, R3, NK, 0, 0, 0, 0);
    add(16'h8000, R3, NK, 0, 0, 0, 0);
    add(16'h8000, R3, NK, 0, 0, 0, 0);
    add(16'h8000, R3, 5'd13, 1, 1, 0, 0);
    add(16'h8000, R1, NK, 0, 0, 1, 0);
    add(16'h8000, R2, NK, 0, 0, 0, 0);
    add(16'h8000, R3, NK, 0, 0, 0, 0);
    add(16'h8000, R3, NK, 0, 0, 0, 0);
    add(16'h8000, R3, NK, 0, 0, 0, 0);
    add(16'h8000, R3, 5'd13, 1, 1, 0, 0);
    add(16'h0000, R3, 5'd13, 1, 0, 0, 0);
    add(16'h0000, R3, 5'd13, 1, 0, 0, 0);
    add(16'h0000, R0, NK, 0, 0, 0, 0);
    // Row 3 col 2 (YES), long hold for auto-repeat.
    add(16'h4000, R1, NK, 0, 0, 0, 0);
    add(16'h4000, R2, NK, 0, 0, 0, 0);
    add(16'h4000, R3, NK, 0, 0, 0, 0);
    add(16'h4000, R3, NK, 0, 0, 0, 0);
    add(16'h4000, R3, NK, 0, 0, 0, 0);
    add(16'h4000, R3, 5'd15, 1, 1, 0, 1);
    add(16'h0000, R3, 5'd15, 1, 0, 0, 0);
    add(16'h0000, R3, 5'd15, 1, 0, 0, 0);
    add(16'h0000, R0, NK, 0, 0, 0, 0);

    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset();
      run_step(i, tbl[i]);
      if (tbl[i].hold_after) hold_run();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
